count_bcd_display: RTL and testbench
====================================

# count_bcd_display

Downstream consumer of the free-running 7-bit counter. Samples its `count` output and converts the binary value to three BCD digits with a sequential double-dabble engine (one shift per clock). It then time-multiplexes the digits onto a single seven-segment bus with leading-zero blanking. It is the display stage that makes the counter's value visible on the board.

## Interface
- `REFRESH_CYCLES`, default 4: clocks each digit stays selected before the mux advances; legal range ≥1.
- `SEG_ACTIVE_LOW`, default 0: when 1, `seg` is bit-inverted (common-anode parts); `dig_sel` is unaffected.

- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset, asynchronous, active-low; assertion clears all state immediately; deassertion is synchronous to `clk` by the system.
- `count` input, 7: binary value from the upstream counter. Declared `[0:6]` to match the counter; `count[0]` is the MSB. Range 0–127.
- `hundreds` output, 4: registered BCD hundreds digit (0–1).
- `tens` output, 4: registered BCD tens digit (0–9).
- `ones` output, 4: registered BCD ones digit (0–9).
- `busy` output, 1: high while a conversion is in flight (SHIFT or UPDATE).
- `upd` output, 1: one-cycle pulse in the cycle after the digit registers load.
- `seg` output, 7: segment pattern; `seg[0]`=a … `seg[6]`=g; active-high when `SEG_ACTIVE_LOW`=0.
- `dig_sel` output, 3: one-hot digit enable; bit0=ones, bit1=tens, bit2=hundreds.

## Operation
- **Internal registers:**
  - `last_bin` (7b): last converted value.
  - `init` flag: set by reset.
  - `sh` (7b): binary shift register.
  - `bcd` (12b): shift accumulator.
  - `bit_cnt` (3b).
  - `ref_cnt`: width to hold `REFRESH_CYCLES`−1.
- **FSM states: IDLE, SHIFT, UPDATE.** Reset state is IDLE.
- **IDLE:** if `init`=1 or `count`≠`last_bin`, capture `count` into `sh` and `last_bin`, clear `bcd`, `bit_cnt`←0, clear `init`, go to SHIFT. Otherwise stay in IDLE.
- **SHIFT:** each edge:
  - Add 3 to every `bcd` nibble that is ≥5.
  - Then shift {`bcd`,`sh`} left one bit (the `sh` MSB enters `bcd[0]`).
  - `bit_cnt`++.
  - After the 7th shift (`bit_cnt`=6 at the edge), go to UPDATE.
- **UPDATE:** load `hundreds`/`tens`/`ones` from `bcd[11:8]`/`bcd[7:4]`/`bcd[3:0]`, go to IDLE.
- **`count` changes while `busy`=1:** ignored. The conversion completes with the captured value, then IDLE sees the mismatch and starts a new conversion on the next edge.
- **Counter wrap 127→0:** handled as an ordinary change.
- **Display mux:**
  - `ref_cnt` counts 0..`REFRESH_CYCLES`−1 and wraps.
  - On wrap, `dig_sel` rotates 001→010→100→001.
  - Runs continuously and independently of the FSM.
- **`seg` generation:** combinational decode of the digit selected by `dig_sel`, taken from the output digit registers.
  - Decode table (active-high, g..a): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- **Blanking:** `seg`=0x00 (before inversion) when:
  - hundreds is selected and `hundreds`=0; or
  - tens is selected and `hundreds`=0 and `tens`=0.
  - Ones is never blanked.
- **Reset values:**
  - Outputs: `hundreds`=`tens`=`ones`=0, `busy`=0, `upd`=0, `dig_sel`=001, `seg`=0x3F (0x40 if `SEG_ACTIVE_LOW`).
  - Internal: `init`=1, `last_bin`=0, `ref_cnt`=0.

## Timing
- **Capture:** IDLE samples `count` at edge E.
- **Shift and load:** SHIFT occupies edges E+1..E+7. UPDATE loads the digits at edge E+8, so new digits are visible after E+8.
- **`upd`:** high for exactly the cycle following E+8. Deasserted at E+9.
- **`busy`:** high from after E until after E+8.
- **Back-to-back:** a new capture is possible at E+9, so minimum conversion period is 9 clocks.
- **First conversion after reset release:** forced by `init` at the first edge, even when `count`=0.
- **Reset mid-conversion:** FSM returns to IDLE; outputs and `init` take their reset values immediately. The conversion is discarded and restarts after release.
- **`dig_sel` timing:** each value holds for `REFRESH_CYCLES` clocks. A digit-register update is reflected in `seg` in the same cycle the registers change.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `count`=0 → all outputs at reset values, `seg`=0x3F. Release → `busy` rises after the first edge, `upd` pulses at edge 9, digits stay 0/0/0.
- **Full-scale conversion:** `count`=127 stable → `hundreds`=1, `tens`=2, `ones`=7 loaded 8 edges after capture. Over a 12-cycle window (`REFRESH_CYCLES`=4), `seg` shows 0x07 when `dig_sel`=001, 0x5B when 010, 0x06 when 100.
- **Leading-zero blanking:** `count`=5 → digits 0/0/5. `seg`=0x6D on ones, 0x00 on tens and hundreds. `count`=40 → tens shows 0x66, hundreds blank, ones 0x3F.
- **Change while busy:** `count` 100→63 on the cycle after capture → first result 1/0/0, `upd` pulse; second capture at E+9; result 0/6/3 at E+17, second `upd` pulse.
- **Upstream wrap:** sweep `count` 120..127→0 every 20 cycles → every conversion matches the decimal value. 127→0 yields 0/0/0 with `upd`.
- **Reset mid-conversion, plus inversion check:** assert `rst` at E+4 of a 99 conversion → no `upd`, digits stay 0. Release → 0/9/9 after 9 edges. Repeat with `SEG_ACTIVE_LOW`=1 → all `seg` values bit-inverted.

Source files
------------

// File: rtl/count_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module   : count_bcd_display_if
// Function : Counter-value input and BCD / seven-segment display outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface count_bcd_display_if;
    logic [0:6] count;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       upd;
    logic [6:0] seg;
    logic [2:0] dig_sel;

    // master supplies the counter value, slave is the display stage
    modport master (output count, input hundreds, tens, ones, busy, upd, seg, dig_sel);
    modport slave  (input count, output hundreds, tens, ones, busy, upd, seg, dig_sel);
endinterface
`default_nettype wire

// File: rtl/count_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : count_bcd_display
// Function : Sequential double-dabble of a 7-bit count, muxed 7-seg display.
// Revision : 1.0 - initial release
// ============================================================================
module count_bcd_display #(
    parameter int REFRESH_CYCLES = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    count_bcd_display_if.slave bus
);
    localparam int c_REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t              r_state;
    logic [6:0]          w_bin;
    logic [6:0]          r_last_bin;
    logic [6:0]          r_sh;
    logic                r_init;
    logic [11:0]         r_bcd;
    logic [11:0]         w_adj;
    logic [2:0]          r_bit_cnt;
    logic [3:0]          r_hundreds;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;
    logic                r_busy;
    logic                r_upd;
    logic [2:0]          r_dig_sel;
    logic [c_REF_W-1:0]  r_ref_cnt;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [6:0]          w_seg;

    // count is declared [0:6]; copying it keeps count[0] as the MSB
    assign w_bin = bus.count;

    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                            : r_bcd[gi*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_last_bin <= 7'd0;
            r_sh       <= 7'd0;
            r_init     <= 1'b1;
            r_bcd      <= 12'd0;
            r_bit_cnt  <= 3'd0;
            r_hundreds <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_busy     <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_init || (w_bin != r_last_bin)) begin
                        r_sh       <= w_bin;
                        r_last_bin <= w_bin;
                        r_bcd      <= 12'd0;
                        r_bit_cnt  <= 3'd0;
                        r_init     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd     <= {w_adj[10:0], r_sh[6]};
                    r_sh      <= {r_sh[5:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd6) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_hundreds <= r_bcd[11:8];
                    r_tens     <= r_bcd[7:4];
                    r_ones     <= r_bcd[3:0];
                    r_busy     <= 1'b0;
                    r_upd      <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Digit refresh runs free of the conversion engine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_cnt <= '0;
            r_dig_sel <= 3'b001;
        end else if (r_ref_cnt == c_REF_MAX) begin
            r_ref_cnt <= '0;
            r_dig_sel <= {r_dig_sel[1:0], r_dig_sel[2]};
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit = r_ones;
        w_blank = 1'b0;
        if (r_dig_sel[2]) begin
            w_digit = r_hundreds;
            w_blank = (r_hundreds == 4'd0);
        end else if (r_dig_sel[1]) begin
            w_digit = r_tens;
            w_blank = (r_hundreds == 4'd0) && (r_tens == 4'd0);
        end
        case (w_digit)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h00;
        endcase
        if (w_blank) begin
            w_seg = 7'h00;
        end
    end

    assign bus.hundreds = r_hundreds;
    assign bus.tens     = r_tens;
    assign bus.ones     = r_ones;
    assign bus.busy     = r_busy;
    assign bus.upd      = r_upd;
    assign bus.dig_sel  = r_dig_sel;
    assign bus.seg      = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
endmodule
`default_nettype wire

// File: tb/tb_count_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_bcd_display
// Function : Scoreboard bench for count_bcd_display (both segment polarities).
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_bcd_display;
    localparam int c_REF = 4;

    logic       clk;
    logic       rst;
    logic [6:0] cnt;
    int         tests = 0;
    int         fails = 0;

    count_bcd_display_if bus0 ();
    count_bcd_display_if bus1 ();
    assign bus0.count = cnt;
    assign bus1.count = cnt;

    count_bcd_display #(.REFRESH_CYCLES(c_REF), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    count_bcd_display #(.REFRESH_CYCLES(c_REF), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h;
        int t;
        int o;
        int upd_at;
    } exp_t;

    exp_t q[$];

    // Reference: a conversion of value v takes 9 clocks, digits are v/100, v/10%10, v%10
    int  n = 0;
    int  m_k = 0;
    int  m_h = 0, m_t = 0, m_o = 0;
    int  p_h = 0, p_t = 0, p_o = 0;
    int  m_last = 0;
    int  m_due = 0;
    int  m_free = 0;
    bit  m_init = 1'b1;
    bit  m_pend = 1'b0;

    always @(posedge clk) begin
        n++;
        if (!rst) begin
            q.delete();
            m_init = 1'b1; m_last = 0; m_pend = 1'b0; m_free = 0; m_k = 0;
            m_h = 0; m_t = 0; m_o = 0;
        end else begin
            m_k++;
            if (m_pend && n == m_due) begin
                m_h = p_h; m_t = p_t; m_o = p_o;
                m_pend = 1'b0;
            end
            if (!m_pend && n >= m_free && (m_init || int'(cnt) != m_last)) begin
                p_h = int'(cnt) / 100;
                p_t = (int'(cnt) / 10) % 10;
                p_o = int'(cnt) % 10;
                q.push_back('{p_h, p_t, p_o, n + 8});
                m_due = n + 8; m_free = n + 9;
                m_pend = 1'b1; m_init = 1'b0; m_last = int'(cnt);
            end
        end
    end

    function automatic int seg_of(int h, int t, int o, int idx);
        int tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
        if (idx == 2) return (h == 0) ? 0 : tbl[h];
        if (idx == 1) return (h == 0 && t == 0) ? 0 : tbl[t];
        return tbl[o];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   idx;
        int   es;
        if (q.size() > 0 && q[0].upd_at < n) begin
            chk("upd_missing", 0, 1);
            void'(q.pop_front());
        end
        if (bus0.upd) begin
            if (q.size() == 0) begin
                chk("upd_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("upd_edge", n, e.upd_at);
                chk("res_hundreds", int'(bus0.hundreds), e.h);
                chk("res_tens", int'(bus0.tens), e.t);
                chk("res_ones", int'(bus0.ones), e.o);
            end
        end
        idx = (m_k / c_REF) % 3;
        es  = seg_of(m_h, m_t, m_o, idx);
        chk("hundreds", int'(bus0.hundreds), m_h);
        chk("tens", int'(bus0.tens), m_t);
        chk("ones", int'(bus0.ones), m_o);
        chk("busy", int'(bus0.busy), int'(m_pend));
        chk("dig_sel", int'(bus0.dig_sel), 1 << idx);
        chk("seg", int'(bus0.seg), es);
        chk("seg_active_low", int'(bus1.seg), es ^ 'h7F);
        chk("dig_sel_active_low", int'(bus1.dig_sel), 1 << idx);
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        cnt = 7'd0;
        cyc(3);
        rst = 1'b1;
        cyc(20);
        cnt = 7'd127; cyc(30);
        cnt = 7'd5;   cyc(20);
        cnt = 7'd40;  cyc(20);
        cnt = 7'd100; cyc(1);
        cnt = 7'd63;  cyc(30);
        for (int v = 120; v <= 128; v++) begin
            cnt = 7'(v % 128);
            cyc(20);
        end
        cnt = 7'd99; cyc(4);
        rst = 1'b0;  cyc(2);
        rst = 1'b1;  cyc(20);
        for (int i = 0; i < 40; i++) begin
            cnt = 7'($urandom_range(127, 0));
            cyc(int'($urandom_range(25, 1)));
        end
        cyc(20);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
